// File: rtl/mci_pkg.sv
// Shared MCI definitions: default bus widths, arbiter FSM states and the
// read-data pattern returned when the ack watchdog fires.
package mci_pkg;

    localparam int MCI_ADDR_W = 14;
    localparam int MCI_DATA_W = 32;
    localparam int MCI_BE_W   = MCI_DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [31:0] MCI_TMO_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mci_rr_pick.sv
// Two-requester round-robin pick: on contention the master that did not win
// last time is chosen; a lone requester always wins.
module mci_rr_pick (
    input  logic val0,
    input  logic val1,
    input  logic last_owner,
    output logic gnt_idx,
    output logic gnt_vld
);

    always_comb begin
        gnt_vld = val0 | val1;
        if (val0 && val1) begin
            gnt_idx = ~last_owner;
        end else begin
            gnt_idx = val1;
        end
    end

endmodule

// File: rtl/mci_arbiter.sv
// Two-master to one-slave MCI arbiter with round-robin grant and single-beat
// transactions. Optional ack watchdog enabled by defining MCI_ARB_TIMEOUT_EN.
module mci_arbiter
  import mci_pkg::*;
#(
  parameter int ADDR_W      = MCI_ADDR_W,
  parameter int DATA_W      = MCI_DATA_W,
  parameter int BE_W        = MCI_BE_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic              i_m0_val,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic [BE_W-1:0]   i_m0_be,
  input  logic              i_m0_rdwn,
  output logic              o_m0_ack,
  output logic [DATA_W-1:0] o_m0_rdata,

  input  logic              i_m1_val,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic [BE_W-1:0]   i_m1_be,
  input  logic              i_m1_rdwn,
  output logic              o_m1_ack,
  output logic [DATA_W-1:0] o_m1_rdata,

  output logic              o_mci_val,
  output logic [ADDR_W-1:0] o_mci_addr,
  output logic [DATA_W-1:0] o_mci_wdata,
  output logic [BE_W-1:0]   o_mci_be,
  output logic              o_mci_rdwn,
  input  logic              i_mci_ack,
  input  logic [DATA_W-1:0] i_mci_rdata,

  output logic              o_owner,
  output logic              o_busy
`ifdef MCI_ARB_TIMEOUT_EN
  ,
  output logic              o_timeout
`endif
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic              owner;
  logic              gnt_idx;
  logic              gnt_vld;
  logic              grant_en;
  logic              tmo_hit;
  logic              ack_cyc;
  logic [DATA_W-1:0] rsp_data;

  mci_rr_pick u_pick (
    .val0       (i_m0_val),
    .val1       (i_m1_val),
    .last_owner (owner),
    .gnt_idx    (gnt_idx),
    .gnt_vld    (gnt_vld)
  );

`ifdef MCI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_cnt <= '0;
    end else if (grant_en) begin
      tmo_cnt <= '0;
    end else if (state == BUSY) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign tmo_hit   = (state == BUSY) && !i_mci_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYC));
  assign rsp_data  = i_mci_ack ? i_mci_rdata : DATA_W'(MCI_TMO_RDATA);
  assign o_timeout = !i_rst && tmo_hit;
`else
  assign tmo_hit  = 1'b0;
  assign rsp_data = i_mci_rdata;
`endif

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_vld) begin
          state_nxt = BUSY;
          grant_en  = 1'b1;
        end
      end
      BUSY: begin
        if (i_mci_ack || tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      owner       <= 1'b1;
      o_mci_addr  <= '0;
      o_mci_wdata <= '0;
      o_mci_be    <= '0;
      o_mci_rdwn  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_en) begin
        owner       <= gnt_idx;
        o_mci_addr  <= gnt_idx ? i_m1_addr  : i_m0_addr;
        o_mci_wdata <= gnt_idx ? i_m1_wdata : i_m0_wdata;
        o_mci_be    <= gnt_idx ? i_m1_be    : i_m0_be;
        o_mci_rdwn  <= gnt_idx ? i_m1_rdwn  : i_m0_rdwn;
      end
    end
  end

  assign o_mci_val = (state == BUSY);
  assign o_busy    = (state == BUSY);
  assign o_owner   = owner;

  assign ack_cyc    = !i_rst && (state == BUSY) && (i_mci_ack || tmo_hit);
  assign o_m0_ack   = ack_cyc && !owner;
  assign o_m1_ack   = ack_cyc && owner;
  assign o_m0_rdata = o_m0_ack ? rsp_data : '0;
  assign o_m1_rdata = o_m1_ack ? rsp_data : '0;

endmodule

// File: tb/tb_mci_arbiter.sv
// Scoreboard bench for mci_arbiter: per-master request queues, an expected
// grant-order queue, and a behavioural slave with fixed ack latency.
module tb_mci_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              i_m0_val, i_m0_rdwn, o_m0_ack;
  logic [ADDR_W-1:0] i_m0_addr;
  logic [DATA_W-1:0] i_m0_wdata, o_m0_rdata;
  logic [BE_W-1:0]   i_m0_be;
  logic              i_m1_val, i_m1_rdwn, o_m1_ack;
  logic [ADDR_W-1:0] i_m1_addr;
  logic [DATA_W-1:0] i_m1_wdata, o_m1_rdata;
  logic [BE_W-1:0]   i_m1_be;
  logic              o_mci_val, o_mci_rdwn, i_mci_ack;
  logic [ADDR_W-1:0] o_mci_addr;
  logic [DATA_W-1:0] o_mci_wdata, i_mci_rdata;
  logic [BE_W-1:0]   o_mci_be;
  logic              o_owner, o_busy;
`ifdef MCI_ARB_TIMEOUT_EN
  logic              o_timeout;
`endif

  always #5 clk = ~clk;

  mci_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .BE_W        (BE_W),
    .TIMEOUT_CYC (8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_m0_val    (i_m0_val),
    .i_m0_addr   (i_m0_addr),
    .i_m0_wdata  (i_m0_wdata),
    .i_m0_be     (i_m0_be),
    .i_m0_rdwn   (i_m0_rdwn),
    .o_m0_ack    (o_m0_ack),
    .o_m0_rdata  (o_m0_rdata),
    .i_m1_val    (i_m1_val),
    .i_m1_addr   (i_m1_addr),
    .i_m1_wdata  (i_m1_wdata),
    .i_m1_be     (i_m1_be),
    .i_m1_rdwn   (i_m1_rdwn),
    .o_m1_ack    (o_m1_ack),
    .o_m1_rdata  (o_m1_rdata),
    .o_mci_val   (o_mci_val),
    .o_mci_addr  (o_mci_addr),
    .o_mci_wdata (o_mci_wdata),
    .o_mci_be    (o_mci_be),
    .o_mci_rdwn  (o_mci_rdwn),
    .i_mci_ack   (i_mci_ack),
    .i_mci_rdata (i_mci_rdata),
    .o_owner     (o_owner),
    .o_busy      (o_busy)
`ifdef MCI_ARB_TIMEOUT_EN
    ,
    .o_timeout   (o_timeout)
`endif
  );

  typedef struct {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] rdata;
  } txn_t;

  txn_t mq0[$];
  txn_t mq1[$];
  logic exp_own_q[$];

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   raise0 = 0;
  int   raise1 = 0;
  int   slv_cnt = 0;
  int   slv_lat = 3;
  bit   cool0, cool1, slv_active, val_prev, lat_chk, drop_bsy;
  txn_t cur;
  logic cur_own;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic rd, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be,
                      input logic [DATA_W-1:0] rdat);
    txn_t t;
    t.rd = rd; t.addr = a; t.wdata = wd; t.be = be; t.rdata = rdat;
    if (m) mq1.push_back(t);
    else   mq0.push_back(t);
  endtask

  task automatic drive_masters();
    logic v0, v1;
    v0 = (mq0.size() > 0) && !cool0;
    v1 = (mq1.size() > 0) && !cool1;
    if (drop_bsy && o_busy && !o_owner) v0 = 1'b0;
    if (drop_bsy && o_busy &&  o_owner) v1 = 1'b0;
    if (v0 && !i_m0_val) raise0 = cyc;
    if (v1 && !i_m1_val) raise1 = cyc;
    i_m0_val = v0;
    i_m1_val = v1;
    if (mq0.size() > 0 && !(o_busy && !o_owner)) begin
      i_m0_rdwn = mq0[0].rd; i_m0_addr = mq0[0].addr;
      i_m0_wdata = mq0[0].wdata; i_m0_be = mq0[0].be;
    end else begin
      i_m0_rdwn = 1'($urandom()); i_m0_addr = ADDR_W'($urandom());
      i_m0_wdata = $urandom(); i_m0_be = BE_W'($urandom());
    end
    if (mq1.size() > 0 && !(o_busy && o_owner)) begin
      i_m1_rdwn = mq1[0].rd; i_m1_addr = mq1[0].addr;
      i_m1_wdata = mq1[0].wdata; i_m1_be = mq1[0].be;
    end else begin
      i_m1_rdwn = 1'($urandom()); i_m1_addr = ADDR_W'($urandom());
      i_m1_wdata = $urandom(); i_m1_be = BE_W'($urandom());
    end
    cool0 = 1'b0;
    cool1 = 1'b0;
  endtask

  task automatic drive_slave();
    if (i_mci_ack) begin
      i_mci_ack   = 1'b0;
      i_mci_rdata = $urandom();
      slv_active  = 1'b0;
    end else begin
      i_mci_rdata = $urandom();
      if (slv_active && slv_lat > 0) begin
        slv_cnt--;
        if (slv_cnt == 0) begin
          i_mci_ack   = 1'b1;
          i_mci_rdata = cur.rdata;
        end
      end
    end
  endtask

  task automatic sample();
    chk("busy_eq_val", o_busy, o_mci_val);
    if (o_mci_val && !val_prev) begin
      chk("grant_expected", exp_own_q.size() > 0, 1'b1);
      if (exp_own_q.size() > 0) begin
        cur_own = exp_own_q.pop_front();
        chk("grant_owner", o_owner, cur_own);
        if (cur_own) cur = mq1[0];
        else         cur = mq0[0];
        chk("grant_addr",  o_mci_addr,  cur.addr);
        chk("grant_wdata", o_mci_wdata, cur.wdata);
        chk("grant_be",    o_mci_be,    cur.be);
        chk("grant_rdwn",  o_mci_rdwn,  cur.rd);
        if (lat_chk) chk("grant_latency", cyc - (cur_own ? raise1 : raise0), 1);
        slv_active = 1'b1;
        slv_cnt    = slv_lat;
      end
    end else if (o_mci_val && slv_active) begin
      chk("hold_addr",  o_mci_addr,  cur.addr);
      chk("hold_wdata", o_mci_wdata, cur.wdata);
      chk("hold_be",    o_mci_be,    cur.be);
    end
    if (i_mci_ack && slv_active) begin
      chk("ack_m0",   o_m0_ack,   !cur_own);
      chk("ack_m1",   o_m1_ack,   cur_own);
      chk("rdata_m0", o_m0_rdata, cur_own ? '0 : cur.rdata);
      chk("rdata_m1", o_m1_rdata, cur_own ? cur.rdata : '0);
      if (cur_own) begin void'(mq1.pop_front()); cool1 = 1'b1; end
      else         begin void'(mq0.pop_front()); cool0 = 1'b1; end
    end else begin
      chk("idle_ack_m0",   o_m0_ack,   1'b0);
      chk("idle_ack_m1",   o_m1_ack,   1'b0);
      chk("idle_rdata_m0", o_m0_rdata, '0);
      chk("idle_rdata_m1", o_m1_rdata, '0);
    end
    val_prev = o_mci_val;
  endtask

  task automatic run(input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      drive_masters();
      drive_slave();
      @(negedge clk);
      sample();
      done = (mq0.size() == 0) && (mq1.size() == 0) && (exp_own_q.size() == 0) && !o_busy;
      n++;
      if (!done && n >= budget) begin
        chk("run_in_budget", done, 1'b1);
        mq0.delete(); mq1.delete(); exp_own_q.delete();
        done = 1'b1;
      end
    end
    i_m0_val = 1'b0;
    i_m1_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_rst = 1'b1;
    i_m0_val = 1'b1; i_m0_addr = '0; i_m0_wdata = '0; i_m0_be = '0; i_m0_rdwn = 1'b0;
    i_m1_val = 1'b0; i_m1_addr = '0; i_m1_wdata = '0; i_m1_be = '0; i_m1_rdwn = 1'b0;
    i_mci_ack = 1'b1; i_mci_rdata = 32'h1234_5678;
    cool0 = 0; cool1 = 0; slv_active = 0; val_prev = 0; lat_chk = 0; drop_bsy = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_val",   o_mci_val,   1'b0);
    chk("rst_busy",  o_busy,      1'b0);
    chk("rst_owner", o_owner,     1'b1);
    chk("rst_addr",  o_mci_addr,  '0);
    chk("rst_wdata", o_mci_wdata, '0);
    chk("rst_be",    o_mci_be,    '0);
    chk("rst_rdwn",  o_mci_rdwn,  1'b0);
    chk("rst_ack0",  o_m0_ack,    1'b0);
    chk("rst_ack1",  o_m1_ack,    1'b0);
    @(posedge clk); #1;
    i_rst = 1'b0; i_m0_val = 1'b0; i_mci_ack = 1'b0;

    push(0, 1'b1, 14'h0100, 32'h0, 4'hF, 32'h0000_0B01);
    push(1, 1'b0, 14'h0200, 32'h1234_5678, 4'h3, 32'h0000_0B02);
    exp_own_q.push_back(0); exp_own_q.push_back(1);
    run(100);
    chk("owner_after_contention", o_owner, 1'b1);

    for (int i = 0; i < 3; i++) begin
      push(0, 1'b1, 14'h0020 + 14'(i), 32'h0, 4'hF, 32'h1000_0000 + i);
      push(1, 1'b0, 14'h0120 + 14'(i), 32'h2000_0000 + i, 4'(i + 1), 32'h3000_0000 + i);
      exp_own_q.push_back(0); exp_own_q.push_back(1);
    end
    run(300);

    lat_chk = 1'b1;
    push(0, 1'b1, 14'h0010, 32'h0, 4'hF, 32'h0000_1140);
    exp_own_q.push_back(0);
    run(100);
    lat_chk = 1'b0;
    chk("owner_after_read", o_owner, 1'b0);

    push(0, 1'b0, 14'h0011, 32'h0F0F_0011, 4'h5, 32'h0000_0111);
    push(1, 1'b1, 14'h0211, 32'h0, 4'hA, 32'h0000_0211);
    exp_own_q.push_back(1); exp_own_q.push_back(0);
    run(100);

    push(1, 1'b0, 14'h0030, 32'hA5A5_0001, 4'hF, 32'h0);
    exp_own_q.push_back(1);
    run(100);

    drop_bsy = 1'b1;
    push(0, 1'b1, 14'h0040, 32'h0, 4'h1, 32'hCAFE_0040);
    exp_own_q.push_back(0);
    run(100);
    drop_bsy = 1'b0;

    @(posedge clk); #1;
    i_mci_ack = 1'b1; i_mci_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("stray_ack0",   o_m0_ack,   1'b0);
    chk("stray_ack1",   o_m1_ack,   1'b0);
    chk("stray_rdata0", o_m0_rdata, '0);
    chk("stray_rdata1", o_m1_rdata, '0);
    @(posedge clk); #1;
    i_mci_ack = 1'b0;
    @(negedge clk);
    chk("stray_no_grant", o_mci_val, 1'b0);

    @(posedge clk); #1;
    i_m1_val = 1'b1; i_m1_rdwn = 1'b0; i_m1_addr = 14'h0050;
    i_m1_wdata = 32'h0BAD_0050; i_m1_be = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busy",  o_busy,  1'b1);
    chk("midrst_owner", o_owner, 1'b1);
    chk("midrst_addr",  o_mci_addr, 14'h0050);
    @(posedge clk); #1;
    i_rst = 1'b1; i_mci_ack = 1'b1; i_mci_rdata = 32'h7777_0050;
    @(negedge clk);
    chk("midrst_ack0", o_m0_ack, 1'b0);
    chk("midrst_ack1", o_m1_ack, 1'b0);
    @(posedge clk); #1;
    i_rst = 1'b0; i_mci_ack = 1'b0; i_m1_val = 1'b0;
    @(negedge clk);
    chk("postrst_val",   o_mci_val, 1'b0);
    chk("postrst_busy",  o_busy,    1'b0);
    chk("postrst_owner", o_owner,   1'b1);
    chk("postrst_ack1",  o_m1_ack,  1'b0);

`ifdef MCI_ARB_TIMEOUT_EN
    @(posedge clk); #1;
    i_m0_val = 1'b1; i_m0_rdwn = 1'b1; i_m0_addr = 14'h0060; i_m0_be = 4'hF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_mci_val && n < 10);
    chk("tmo_grant", o_mci_val, 1'b1);
    n = 0;
    while (!o_m0_ack && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles",  n,          8);
    chk("tmo_rdata",   o_m0_rdata, 32'hDEAD_BEEF);
    chk("tmo_flag",    o_timeout,  1'b1);
    chk("tmo_ack1",    o_m1_ack,   1'b0);
    @(posedge clk); #1;
    i_m0_val = 1'b0;
    @(negedge clk);
    chk("tmo_idle_val",  o_mci_val, 1'b0);
    chk("tmo_flag_done", o_timeout, 1'b0);
`else
    n = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
